// File: rtl/id_stage_pkg.sv
// Shared opcode constants, ALU encodings and the control-decode helper for the RV32I ID stage.
package id_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic     write_reg;
        logic     mem_write;
        logic     mem_read;
        logic     src_immd;
        logic     branch;
        imm_fmt_e fmt;
    } ctrl_t;

    // Unknown opcodes fall through to an all-zero bubble.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_OP: begin
                c.write_reg = 1'b1;
            end
            OPC_OP_IMM, OPC_JALR: begin
                c.write_reg = 1'b1;
                c.src_immd  = 1'b1;
                c.fmt       = IMM_I;
            end
            OPC_LOAD: begin
                c.write_reg = 1'b1;
                c.mem_read  = 1'b1;
                c.src_immd  = 1'b1;
                c.fmt       = IMM_I;
            end
            OPC_STORE: begin
                c.mem_write = 1'b1;
                c.src_immd  = 1'b1;
                c.fmt       = IMM_S;
            end
            OPC_BRANCH: begin
                c.branch = 1'b1;
                c.fmt    = IMM_B;
            end
            OPC_JAL: begin
                c.write_reg = 1'b1;
                c.src_immd  = 1'b1;
                c.fmt       = IMM_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                c.write_reg = 1'b1;
                c.src_immd  = 1'b1;
                c.fmt       = IMM_U;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two combinational read ports with write-through bypass,
// one write port, asynchronous active-low clear. x0 always reads zero.
module id_regfile
    import id_stage_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [REG_SEL-1:0]   wsel_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [REG_SEL-1:0]   rsel1_i,
    input  logic [REG_SEL-1:0]   rsel2_i,
    output logic [WORD_SIZE-1:0] rdata1_o,
    output logic [WORD_SIZE-1:0] rdata2_o
);

    logic [WORD_SIZE-1:0] mem_q [NUM_REGS];
    logic [WORD_SIZE-1:0] mem_d [NUM_REGS];
    logic                 wr_en;

    assign wr_en = we_i && (wsel_i != '0);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wsel_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Reads are forced to zero while reset is held so a bypassed write cannot leak through.
    always_comb begin
        rdata1_o = '0;
        if (rst && (rsel1_i != '0)) begin
            rdata1_o = (wr_en && (wsel_i == rsel1_i)) ? wdata_i : mem_q[rsel1_i];
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (rst && (rsel2_i != '0)) begin
            rdata2_o = (wr_en && (wsel_i == rsel2_i)) ? wdata_i : mem_q[rsel2_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register file reads, immediate generation and
// control decode, all combinational from the IF/ID instruction word.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 reg_write,
    input  logic [WORD_SIZE-1:0] rd_data,
    input  logic [REG_SEL-1:0]   rd_select,
    output logic [WORD_SIZE-1:0] immd,
    output logic [WORD_SIZE-1:0] data1,
    output logic [WORD_SIZE-1:0] data2,
    output logic [3:0]           alu_op,
    output logic [REG_SEL-1:0]   destination,
    output logic                 write_reg,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic                 src_immd,
    output logic                 branch
);

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7_b5;
    ctrl_t              ctrl;
    logic signed [31:0] imm32;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];
    assign ctrl      = decode_ctrl(opcode);

    id_regfile #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_REGS  (NUM_REGS),
        .REG_SEL   (REG_SEL)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (reg_write),
        .wsel_i    (rd_select),
        .wdata_i   (rd_data),
        .rsel1_i   (REG_SEL'(instr[19:15])),
        .rsel2_i   (REG_SEL'(instr[24:20])),
        .rdata1_o  (data1),
        .rdata2_o  (data2)
    );

    // Immediates are assembled in 32 bits, then sign-extended to the datapath width.
    always_comb begin
        imm32 = '0;
        case (ctrl.fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign immd = WORD_SIZE'(imm32);

    // Only shifts use bit 30 on OP-IMM; elsewhere it is part of the immediate.
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OPC_OP:     alu_op = {funct7_b5, funct3};
            OPC_OP_IMM: alu_op = (funct3 == F3_SRX) ? {funct7_b5, funct3} : {1'b0, funct3};
            OPC_BRANCH: alu_op = ALU_SUB;
            default:    alu_op = ALU_ADD;
        endcase
    end

    assign write_reg   = ctrl.write_reg;
    assign mem_write   = ctrl.mem_write;
    assign mem_read    = ctrl.mem_read;
    assign src_immd    = ctrl.src_immd;
    assign branch      = ctrl.branch;
    assign destination = ctrl.write_reg ? REG_SEL'(instr[11:7]) : '0;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: register file, bypass, immediates and control decode.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        reg_write;
    logic [31:0] rd_data;
    logic [4:0]  rd_select;
    logic [31:0] immd;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [3:0]  alu_op;
    logic [4:0]  destination;
    logic        write_reg;
    logic        mem_write;
    logic        mem_read;
    logic        src_immd;
    logic        branch;
    logic [4:0]  ctl;

    int checks = 0;
    int errors = 0;

    id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .reg_write   (reg_write),
        .rd_data     (rd_data),
        .rd_select   (rd_select),
        .immd        (immd),
        .data1       (data1),
        .data2       (data2),
        .alu_op      (alu_op),
        .destination (destination),
        .write_reg   (write_reg),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .src_immd    (src_immd),
        .branch      (branch)
    );

    // {write_reg, mem_write, mem_read, src_immd, branch}
    assign ctl = {write_reg, mem_write, mem_read, src_immd, branch};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [4:0] sel, input logic [31:0] val);
        @(negedge clk);
        reg_write = 1'b1;
        rd_select = sel;
        rd_data   = val;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        rd_select = '0;
        rd_data   = '0;
    endtask

    task automatic test_reset;
        instr = 32'h0; reg_write = 1'b0; rd_data = '0; rd_select = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #3;
        checks++; if (data1 !== 32'h0) begin errors++; $display("FAIL reset_data1 got %h exp %h", data1, 32'h0); end
        checks++; if (data2 !== 32'h0) begin errors++; $display("FAIL reset_data2 got %h exp %h", data2, 32'h0); end
        checks++; if (immd !== 32'h0) begin errors++; $display("FAIL reset_immd got %h exp %h", immd, 32'h0); end
        checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 5'b00000); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL reset_alu got %b exp %b", alu_op, 4'b0000); end
        checks++; if (destination !== 5'd0) begin errors++; $display("FAIL reset_dest got %0d exp %0d", destination, 0); end
        // A bypassed write while reset is held must not show on the read port.
        instr = 32'h00028093; reg_write = 1'b1; rd_select = 5'd5; rd_data = 32'h5555;
        #1;
        checks++; if (data1 !== 32'h0) begin errors++; $display("FAIL reset_read_gate got %h exp %h", data1, 32'h0); end
        reg_write = 1'b0; rd_select = '0; rd_data = '0; instr = 32'h0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_addi;
        wr(5'd29, 32'h00011000);
        @(negedge clk);
        instr = 32'h00c00713;
        #1;
        checks++; if (immd !== 32'd12) begin errors++; $display("FAIL addi_immd got %h exp %h", immd, 32'd12); end
        checks++; if (data1 !== 32'h0) begin errors++; $display("FAIL addi_data1 got %h exp %h", data1, 32'h0); end
        checks++; if (ctl !== 5'b10010) begin errors++; $display("FAIL addi_ctl got %b exp %b", ctl, 5'b10010); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL addi_alu got %b exp %b", alu_op, 4'b0000); end
        checks++; if (destination !== 5'd14) begin errors++; $display("FAIL addi_dest got %0d exp %0d", destination, 14); end
    endtask

    task automatic test_add;
        wr(5'd14, 32'd12);
        @(negedge clk);
        instr = 32'h00ee8c33;
        #1;
        checks++; if (data1 !== 32'h00011000) begin errors++; $display("FAIL add_data1 got %h exp %h", data1, 32'h00011000); end
        checks++; if (data2 !== 32'd12) begin errors++; $display("FAIL add_data2 got %h exp %h", data2, 32'd12); end
        checks++; if (ctl !== 5'b10000) begin errors++; $display("FAIL add_ctl got %b exp %b", ctl, 5'b10000); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL add_alu got %b exp %b", alu_op, 4'b0000); end
        checks++; if (destination !== 5'd24) begin errors++; $display("FAIL add_dest got %0d exp %0d", destination, 24); end
        checks++; if (immd !== 32'h0) begin errors++; $display("FAIL add_immd got %h exp %h", immd, 32'h0); end
    endtask

    task automatic test_load;
        wr(5'd24, 32'h00011000);
        @(negedge clk);
        instr = 32'h200c2803;
        #1;
        checks++; if (data1 !== 32'h00011000) begin errors++; $display("FAIL lw_data1 got %h exp %h", data1, 32'h00011000); end
        checks++; if (immd !== 32'd512) begin errors++; $display("FAIL lw_immd got %h exp %h", immd, 32'd512); end
        checks++; if (ctl !== 5'b10110) begin errors++; $display("FAIL lw_ctl got %b exp %b", ctl, 5'b10110); end
        // rd field of 0x200c2803 (bits 11:7) is 10000 = x16.
        checks++; if (destination !== 5'd16) begin errors++; $display("FAIL lw_dest got %0d exp %0d", destination, 16); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL lw_alu got %b exp %b", alu_op, 4'b0000); end
    endtask

    task automatic test_store;
        wr(5'd16, 32'd71);
        @(negedge clk);
        instr = 32'hed071fa3;
        #1;
        checks++; if (data1 !== 32'd12) begin errors++; $display("FAIL sh_data1 got %h exp %h", data1, 32'd12); end
        checks++; if (data2 !== 32'd71) begin errors++; $display("FAIL sh_data2 got %h exp %h", data2, 32'd71); end
        checks++; if (immd !== 32'hFFFFFEDF) begin errors++; $display("FAIL sh_immd got %h exp %h", immd, 32'hFFFFFEDF); end
        checks++; if (ctl !== 5'b01010) begin errors++; $display("FAIL sh_ctl got %b exp %b", ctl, 5'b01010); end
        checks++; if (destination !== 5'd0) begin errors++; $display("FAIL sh_dest got %0d exp %0d", destination, 0); end
    endtask

    task automatic test_branch_upper_jump;
        @(negedge clk);
        instr = 32'h00208463;  // beq x1,x2,8
        #1;
        checks++; if (immd !== 32'd8) begin errors++; $display("FAIL beq_immd got %h exp %h", immd, 32'd8); end
        checks++; if (ctl !== 5'b00001) begin errors++; $display("FAIL beq_ctl got %b exp %b", ctl, 5'b00001); end
        checks++; if (alu_op !== 4'b1000) begin errors++; $display("FAIL beq_alu got %b exp %b", alu_op, 4'b1000); end
        checks++; if (destination !== 5'd0) begin errors++; $display("FAIL beq_dest got %0d exp %0d", destination, 0); end
        instr = 32'h123451B7;  // lui x3,0x12345
        #1;
        checks++; if (immd !== 32'h12345000) begin errors++; $display("FAIL lui_immd got %h exp %h", immd, 32'h12345000); end
        checks++; if (ctl !== 5'b10010) begin errors++; $display("FAIL lui_ctl got %b exp %b", ctl, 5'b10010); end
        checks++; if (destination !== 5'd3) begin errors++; $display("FAIL lui_dest got %0d exp %0d", destination, 3); end
        instr = 32'hFFDFF0EF;  // jal x1,-4
        #1;
        checks++; if (immd !== 32'hFFFFFFFC) begin errors++; $display("FAIL jal_immd got %h exp %h", immd, 32'hFFFFFFFC); end
        checks++; if (ctl !== 5'b10010) begin errors++; $display("FAIL jal_ctl got %b exp %b", ctl, 5'b10010); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL jal_alu got %b exp %b", alu_op, 4'b0000); end
    endtask

    task automatic test_alu_ops;
        @(negedge clk);
        instr = 32'h402081B3;  // sub x3,x1,x2
        #1;
        checks++; if (alu_op !== 4'b1000) begin errors++; $display("FAIL sub_alu got %b exp %b", alu_op, 4'b1000); end
        instr = 32'h40315093;  // srai x1,x2,3
        #1;
        checks++; if (alu_op !== 4'b1101) begin errors++; $display("FAIL srai_alu got %b exp %b", alu_op, 4'b1101); end
        instr = 32'hFFF14093;  // xori x1,x2,-1
        #1;
        checks++; if (alu_op !== 4'b0100) begin errors++; $display("FAIL xori_alu got %b exp %b", alu_op, 4'b0100); end
        checks++; if (immd !== 32'hFFFFFFFF) begin errors++; $display("FAIL xori_immd got %h exp %h", immd, 32'hFFFFFFFF); end
        instr = 32'hFFFFFFFF;  // unknown opcode
        #1;
        checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL unk_ctl got %b exp %b", ctl, 5'b00000); end
        checks++; if (immd !== 32'h0) begin errors++; $display("FAIL unk_immd got %h exp %h", immd, 32'h0); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL unk_alu got %b exp %b", alu_op, 4'b0000); end
        checks++; if (destination !== 5'd0) begin errors++; $display("FAIL unk_dest got %0d exp %0d", destination, 0); end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        instr     = 32'h00028093;  // addi x1,x5,0
        reg_write = 1'b1;
        rd_select = 5'd5;
        rd_data   = 32'h0000DEAD;
        #1;
        checks++; if (data1 !== 32'h0000DEAD) begin errors++; $display("FAIL bypass_data1 got %h exp %h", data1, 32'h0000DEAD); end
        @(posedge clk);
        #1;
        reg_write = 1'b0; rd_select = '0; rd_data = '0;
        #1;
        checks++; if (data1 !== 32'h0000DEAD) begin errors++; $display("FAIL bypass_stored got %h exp %h", data1, 32'h0000DEAD); end
    endtask

    task automatic test_x0;
        @(negedge clk);
        instr     = 32'h00000093;  // addi x1,x0,0
        reg_write = 1'b1;
        rd_select = 5'd0;
        rd_data   = 32'h00001234;
        #1;
        checks++; if (data1 !== 32'h0) begin errors++; $display("FAIL x0_bypass got %h exp %h", data1, 32'h0); end
        @(posedge clk);
        #1;
        reg_write = 1'b0; rd_data = '0;
        #1;
        checks++; if (data1 !== 32'h0) begin errors++; $display("FAIL x0_stored got %h exp %h", data1, 32'h0); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        instr = 32'h00ee8c33;  // add x24,x29,x14
        #1;
        checks++; if (data1 !== 32'h00011000) begin errors++; $display("FAIL areset_pre got %h exp %h", data1, 32'h00011000); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (data1 !== 32'h0) begin errors++; $display("FAIL areset_data1 got %h exp %h", data1, 32'h0); end
        checks++; if (destination !== 5'd24) begin errors++; $display("FAIL areset_dest got %0d exp %0d", destination, 24); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (data1 !== 32'h0) begin errors++; $display("FAIL areset_cleared1 got %h exp %h", data1, 32'h0); end
        checks++; if (data2 !== 32'h0) begin errors++; $display("FAIL areset_cleared2 got %h exp %h", data2, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_add();
        test_load();
        test_store();
        test_branch_upper_jump();
        test_alu_ops();
        test_bypass();
        test_x0();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
